ucode_programmer: RTL
=====================

# ucode_programmer

Microcode image writer for the 8-bit CPU's control store. On `start` it generates every control word of the instruction set and writes it byte-by-byte into the two 8-bit-wide microcode EEPROM halves through their `ce_n`/`we_n`/`oe_n` interface. It is the write-side counterpart of the control unit, which only reads those EEPROMs. With verify compiled in, it reads the image back and flags the first mismatch.

## Interface
- `WE_PULSE`, 2: cycles `ee_we_n` is held low per byte (≥1).
- `WR_WAIT`, 4: idle cycles after each write for the EEPROM write cycle (≥0).
- `RD_LAT`, 2: cycles from read address valid to `ee_rdata` sampling (≥1; verify only).
- `clk` in 1: clock, all logic on rising edge.
- `clr` in 1: synchronous active-high reset.
- `start` in 1: single-cycle request to program; ignored while `busy`.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: sticky completion; cleared by accepted `start` or `clr`.
- `err` out 1: verify mismatch seen (sticky, same clearing as `done`).
- `err_addr` out 11: address of first mismatch.
- `ee_addr` out 11: EEPROM address `{1'b0, zf, cf, half, ir[3:0], step[2:0]}`.
- `ee_wdata` out 8: write data.
- `ee_wdata_en` out 1: high while `ee_wdata` drives the data bus.
- `ee_rdata` in 8: read data.
- `ee_ce_n`, `ee_we_n`, `ee_oe_n` out 1 each: active-low EEPROM strobes.

## Operation
- Address walk: linear 0x000→0x3FF (1024 bytes); bit 10 always 0. `half`=addr[7]: 0 = high byte (hlt,mi,ri,ro,io,ii,ai,ao), 1 = low byte (eo,su,bi,oi,ce,co,j,fi). Stored values are active-high.
- Control word bits 15..0: hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi.
- All opcodes: step0 = 0x4004 (MI|CO), step1 = 0x1408 (RO|II|CE).
- step2/3/4: LDA(1) 0x4800/0x1200/0; ADD(2) 0x4800/0x1020/0x0281; SUB(3) 0x4800/0x1020/0x02C1; STA(4) 0x4800/0x2100/0; LDI(5) 0x0A00; JMP(6) 0x0802; JC(7) 0x0802 only when cf=1; JZ(8) 0x0802 only when zf=1; OUT(14) 0x0110; HLT(15) 0x8000. Unlisted opcode/step combos and steps 5–7 are 0x0000.
- FSM: IDLE → W_SETUP(1) → W_PULSE(`WE_PULSE`) → W_HOLD(1) → W_WAIT(`WR_WAIT`) → next address or, after 0x3FF, VERIFY/DONE.
- W_SETUP: `ee_ce_n`=0, address and data valid, `ee_wdata_en`=1. W_PULSE: `ee_we_n`=0. W_HOLD: `ee_we_n`=1, address/data held. W_WAIT: `ee_ce_n`=1, `ee_wdata_en`=0.
- `ee_we_n` and `ee_oe_n` never low together; `ee_wdata_en`=0 whenever `ee_oe_n`=0.
- DONE: `busy`=0, `done`=1, strobes inactive; returns to IDLE-equivalent, accepts new `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `err_addr`=0, `ee_addr`=0, `ee_wdata`=0, `ee_wdata_en`=0, `ee_ce_n`=`ee_we_n`=`ee_oe_n`=1.
- `start` at edge N → W_SETUP at N+1 (`busy`=1).
- Per byte: 2+`WE_PULSE`+`WR_WAIT` cycles (8 default); write pass 8192 cycles; `done` asserts the cycle after last W_WAIT.
- `clr` mid-operation: next edge all outputs to reset values; EEPROM left partially written; next `start` restarts at 0x000.
- `start` coincident with `clr`: `clr` wins.

## Configuration
- `UCODE_VERIFY_EN` defined: after write pass, read pass 0x000→0x3FF; per byte R_SETUP (`ee_ce_n`=0,`ee_oe_n`=0) held `RD_LAT` cycles, `ee_rdata` sampled on last, then 1 idle cycle. First mismatch: `err`=1, `err_addr`=address, go straight to DONE. Per read byte `RD_LAT`+1 cycles.
- Undefined: no read pass; `ee_oe_n` tied 1, `err`=0, `err_addr`=0; `ee_rdata` unused.

## Test plan
- Reset: hold `clr` 2 cycles → all outputs at reset values; `start` ignored while `clr`=1.
- Full write, EEPROM model: captured image at 0x000=0x40, 0x080=0x04, 0x01C=0x02, 0x09C=0xC1, 0x07A=0x80, 0x0FA=0x00; exactly 1024 `ee_we_n` pulses each `WE_PULSE` cycles wide; `done` at cycle 8193 after `start`.
- Conditional jumps: 0x03A=0x00, 0x0BA=0x00; 0x13A=0x08, 0x1BA=0x02; 0x242=0x08, 0x2C2=0x02; 0x342=0x08.
- Abort: `clr` during byte 100 → next cycle strobes inactive, `busy`=0; new `start` → first write at 0x000.
- Re-start/ignore: `start` pulses while `busy` → no restart (address sequence monotonic); `start` after `done` → `done` clears next cycle.
- `UCODE_VERIFY_EN`: model corrupts 0x13A on readback → `err`=1, `err_addr`=0x13A, `done`=1, no reads beyond 0x13A; clean model → `err`=0.

Source files
------------

// File: rtl/ucode_programmer_if.sv
// EEPROM-side bus of the microcode programmer: address/data, strobes and read-back data.
interface ucode_programmer_if;
  logic [10:0] ee_addr;
  logic [7:0]  ee_wdata;
  logic        ee_wdata_en;
  logic [7:0]  ee_rdata;
  logic        ee_ce_n;
  logic        ee_we_n;
  logic        ee_oe_n;

  modport master (
    output ee_addr, ee_wdata, ee_wdata_en, ee_ce_n, ee_we_n, ee_oe_n,
    input  ee_rdata
  );

  modport slave (
    input  ee_addr, ee_wdata, ee_wdata_en, ee_ce_n, ee_we_n, ee_oe_n,
    output ee_rdata
  );
endinterface

// File: rtl/ucode_programmer.sv
// Writes the full 1024-byte control-store image into the two microcode EEPROM halves.
// Optional read-back verify pass is compiled in with UCODE_VERIFY_EN.
module ucode_programmer #(
  parameter int WE_PULSE = 2,
  parameter int WR_WAIT  = 4,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] err_addr,
  ucode_programmer_if.master ee
);
`ifdef UCODE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [7:0] PULSE_LAST = 8'(WE_PULSE - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(WR_WAIT - 1);
  localparam logic [7:0] RD_LAST    = 8'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, W_WAIT, R_SETUP, R_IDLE, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [9:0]  err_addr_q, err_addr_d;
  logic        wr_next, rd_next, wr_act;

  logic [3:0]  op;
  logic [2:0]  st;
  logic        zf, cf, half;
  logic [15:0] cw;
  logic [7:0]  byte_w;

  assign zf   = addr_q[9];
  assign cf   = addr_q[8];
  assign half = addr_q[7];
  assign op   = addr_q[6:3];
  assign st   = addr_q[2:0];

  // Control word for the current address; jumps taken only when their flag is set.
  always_comb begin
    cw = 16'h0000;
    case (st)
      3'd0: cw = 16'h4004;
      3'd1: cw = 16'h1408;
      3'd2: case (op)
        4'd1, 4'd2, 4'd3, 4'd4: cw = 16'h4800;
        4'd5:  cw = 16'h0A00;
        4'd6:  cw = 16'h0802;
        4'd7:  cw = cf ? 16'h0802 : 16'h0000;
        4'd8:  cw = zf ? 16'h0802 : 16'h0000;
        4'd14: cw = 16'h0110;
        4'd15: cw = 16'h8000;
        default: ;
      endcase
      3'd3: case (op)
        4'd1:       cw = 16'h1200;
        4'd2, 4'd3: cw = 16'h1020;
        4'd4:       cw = 16'h2100;
        default: ;
      endcase
      3'd4: case (op)
        4'd2: cw = 16'h0281;
        4'd3: cw = 16'h02C1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign byte_w = half ? cw[7:0] : cw[15:8];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    wr_next    = 1'b0;
    rd_next    = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d    = W_SETUP;
        addr_d     = '0;
        cnt_d      = '0;
        err_d      = 1'b0;
        err_addr_d = '0;
      end
      W_SETUP: state_d = W_PULSE;
      W_PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = W_HOLD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
      W_HOLD: if (WR_WAIT == 0) wr_next = 1'b1;
              else state_d = W_WAIT;
      W_WAIT: if (cnt_q == WAIT_LAST) wr_next = 1'b1;
              else cnt_d = cnt_q + 8'd1;
      R_SETUP: if (cnt_q == RD_LAST) begin
        cnt_d = '0;
        if (ee.ee_rdata != byte_w) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = DONE;
        end else state_d = R_IDLE;
      end else cnt_d = cnt_q + 8'd1;
      R_IDLE: rd_next = 1'b1;
    endcase

    if (wr_next) begin
      cnt_d = '0;
      if (&addr_q) begin
        addr_d  = '0;
        state_d = VERIFY ? R_SETUP : DONE;
      end else begin
        addr_d  = addr_q + 10'd1;
        state_d = W_SETUP;
      end
    end
    if (rd_next) begin
      if (&addr_q) state_d = DONE;
      else begin
        addr_d  = addr_q + 10'd1;
        state_d = R_SETUP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wr_act         = state_q inside {W_SETUP, W_PULSE, W_HOLD};
  assign busy           = !(state_q inside {IDLE, DONE});
  assign done           = state_q == DONE;
  assign err            = err_q;
  assign err_addr       = {1'b0, err_addr_q};
  assign ee.ee_addr     = {1'b0, addr_q};
  assign ee.ee_wdata    = wr_act ? byte_w : 8'h00;
  assign ee.ee_wdata_en = wr_act;
  assign ee.ee_ce_n     = !(wr_act || state_q == R_SETUP);
  assign ee.ee_we_n     = state_q != W_PULSE;
`ifdef UCODE_VERIFY_EN
  assign ee.ee_oe_n     = state_q != R_SETUP;
`else
  assign ee.ee_oe_n     = 1'b1;
`endif
endmodule
